s_axil_register_file: RTL and testbench
=======================================

// Module: s_axil_register_file
// PURPOSE
//   AXI4-Lite slave register file: NUM_REG word registers, read/write over AXI-Lite.
//   Sits directly downstream of the m_axil_register_bfm master and terminates its transactions.
//   Synthesizable. Single-outstanding per direction; write and read paths run independently.
// PARAMETERS
//   S_AXI_DATA_WIDTH  32  data width in bits; must be 32 or 64; WSTRB width = S_AXI_DATA_WIDTH/8
//   S_AXI_ADDR_WIDTH  32  byte address width
//   NUM_REG           16  number of registers; power of two, >= 2
// PORTS
//   ACLK     in   1       clock; all logic on rising edge
//   ARESET   in   1       asynchronous reset, active-low (0 = reset)
//   AWADDR   in   ADDR    write address
//   AWVALID  in   1       write address valid
//   AWREADY  out  1       write address ready
//   WDATA    in   DATA    write data
//   WSTRB    in   DATA/8  byte-lane write enables
//   WVALID   in   1       write data valid
//   WREADY   out  1       write data ready
//   BRESP    out  2       write response (00 OKAY, 10 SLVERR)
//   BVALID   out  1       write response valid
//   BREADY   in   1       write response ready
//   ARADDR   in   ADDR    read address
//   ARVALID  in   1       read address valid
//   ARREADY  out  1       read address ready
//   RDATA    out  DATA    read data
//   RRESP    out  2       read response
//   RVALID   out  1       read data valid
//   RREADY   in   1       read data ready
// BEHAVIOUR
//   Reset (ARESET=0, async): all registers 0; aw_held=w_held=0; BVALID=RVALID=0; BRESP=RRESP=00;
//     RDATA=0; AWREADY=WREADY=ARREADY=1. Reset mid-transaction drops it; no response is issued.
//   Decode: ADDR_LSB = log2(DATA/8); index = addr[ADDR_LSB +: log2(NUM_REG)]; low bits ignored.
//     In range: addr < NUM_REG*DATA/8.
//   Write path:
//     AWREADY = !aw_held; WREADY = !w_held. A handshake latches addr/data+strb, sets its held flag.
//     AW and W accepted in either order or same cycle; master never waits on our ready.
//     Commit edge: aw_held & w_held & !BVALID -> bytes with WSTRB[k]=1 updated, others kept;
//       BVALID<=1, BRESP set, both held flags cleared. Min latency: handshake edge -> BVALID next cycle.
//     BVALID stays 1, BRESP stable, until BVALID&BREADY; next commit waits for that edge.
//     WSTRB=0: no bytes change, OKAY response still issued.
//   Read path:
//     ARREADY = !RVALID. On AR handshake: RDATA<=reg[index], RRESP set, RVALID<=1 (1-cycle latency).
//     RDATA/RRESP stable while RVALID & !RREADY; RVALID cleared on RVALID&RREADY edge.
//   Same-edge write commit and AR handshake to the same register: RDATA returns the pre-write value.
//   No combinational path from any input to any VALID/RDATA/RESP output.
// CONFIGURATION
//   AXIL_REG_SLVERR_EN defined: out-of-range write -> no register modified, BRESP=10;
//     out-of-range read -> RDATA=0, RRESP=10.
//   Not defined: no range check; address aliases via index (mod NUM_REG); responses always 00.
// TESTING
//   1 Reset: ARESET=0 for 5 cycles, release -> AWREADY=WREADY=ARREADY=1, BVALID=RVALID=0;
//     read 0x00..0x3C -> all 0x00000000, RRESP=00.
//   2 Sequential: write 1..16 to 0x00,0x04..0x3C (WSTRB=F, W one cycle after AW) -> 16 BRESP=00;
//     read back -> 1..16 in order, RRESP=00.
//   3 Strobes: write 0xAABBCCDD @0x08 (F), then 0x11223344 @0x08 WSTRB=0101 -> read 0xAA22CC44.
//   4 Ordering: WVALID 3 cycles before AWVALID -> WREADY=0 after W accept, exactly one BVALID
//     1 cycle after AW handshake; AW+W same cycle -> BVALID next cycle.
//   5 Backpressure: BREADY=0 for 5 cycles -> BVALID/BRESP held, next AW/W held, AWREADY=0;
//     RREADY=0 5 cycles -> RDATA stable, ARREADY=0; both released -> queued write commits.
//   6 Range/hazard: with macro, write 0x5A @0x40 -> BRESP=10, reg0 unchanged; read 0x40 -> 0,
//     RRESP=10; without macro -> write @0x40 lands in reg0, OKAY. Write 0x7 @0x0C with
//     same-edge read 0x0C -> old value; following read -> 0x7.

Source files
------------

// File: rtl/s_axil_register_file_if.sv
// AXI4-Lite bus bundle between a register-file master and the s_axil_register_file slave.
// Signal names follow the AXI4-Lite channel names; the master/slave modports fix directions.
interface s_axil_register_file_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    // Write address channel
    logic [ADDR_W-1:0]   AWADDR;
    logic                AWVALID;
    logic                AWREADY;
    // Write data channel
    logic [DATA_W-1:0]   WDATA;
    logic [DATA_W/8-1:0] WSTRB;
    logic                WVALID;
    logic                WREADY;
    // Write response channel
    logic [1:0]          BRESP;
    logic                BVALID;
    logic                BREADY;
    // Read address channel
    logic [ADDR_W-1:0]   ARADDR;
    logic                ARVALID;
    logic                ARREADY;
    // Read data channel
    logic [DATA_W-1:0]   RDATA;
    logic [1:0]          RRESP;
    logic                RVALID;
    logic                RREADY;

    modport master (
        output AWADDR, AWVALID, input AWREADY,
        output WDATA, WSTRB, WVALID, input WREADY,
        input  BRESP, BVALID, output BREADY,
        output ARADDR, ARVALID, input ARREADY,
        input  RDATA, RRESP, RVALID, output RREADY
    );

    modport slave (
        input  AWADDR, AWVALID, output AWREADY,
        input  WDATA, WSTRB, WVALID, output WREADY,
        output BRESP, BVALID, input BREADY,
        input  ARADDR, ARVALID, output ARREADY,
        output RDATA, RRESP, RVALID, input RREADY
    );
endinterface

// File: rtl/s_axil_register_file.sv
// AXI4-Lite slave register file: NUM_REG word registers with byte-strobed writes.
// Write and read paths are independent, each with one transaction outstanding.
// AW and W are latched separately and committed together once no response is pending.
// Every VALID/RESP/RDATA output comes straight from a flop.
// Optional feature: define AXIL_REG_SLVERR_EN to reject out-of-range accesses with SLVERR;
// otherwise addresses alias modulo NUM_REG and responses are always OKAY.
module s_axil_register_file #(
    parameter int S_AXI_DATA_WIDTH = 32,
    parameter int S_AXI_ADDR_WIDTH = 32,
    parameter int NUM_REG          = 16
) (
    input  logic ACLK,
    input  logic ARESET,
    s_axil_register_file_if.slave s_axil
);
    localparam int STRB_W      = S_AXI_DATA_WIDTH / 8;
    localparam int ADDR_LSB    = $clog2(STRB_W);
    localparam int IDX_W       = $clog2(NUM_REG);
    localparam int RANGE_BYTES = NUM_REG * STRB_W;
    localparam logic [S_AXI_ADDR_WIDTH-1:0] RANGE_LIMIT = S_AXI_ADDR_WIDTH'(RANGE_BYTES);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Replace only the byte lanes whose strobe is set.
    function automatic logic [S_AXI_DATA_WIDTH-1:0] merge_bytes(
        input logic [S_AXI_DATA_WIDTH-1:0] old_word,
        input logic [S_AXI_DATA_WIDTH-1:0] new_word,
        input logic [STRB_W-1:0]           strb
    );
        logic [S_AXI_DATA_WIDTH-1:0] res;
        res = old_word;
        for (int k = 0; k < STRB_W; k++) begin
            if (strb[k]) begin
                res[8*k +: 8] = new_word[8*k +: 8];
            end
        end
        return res;
    endfunction

    // Register storage
    logic [S_AXI_DATA_WIDTH-1:0] regs_q [NUM_REG];

    // Write path state
    logic                        aw_held_q;
    logic [S_AXI_ADDR_WIDTH-1:0] awaddr_q;
    logic                        w_held_q;
    logic [S_AXI_DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]           wstrb_q;
    logic                        bvalid_q;
    logic [1:0]                  bresp_q;

    // Read path state
    logic                        rvalid_q;
    logic [1:0]                  rresp_q;
    logic [S_AXI_DATA_WIDTH-1:0] rdata_q;

    // Handshake and decode wires
    logic             aw_hs_s;
    logic             w_hs_s;
    logic             ar_hs_s;
    logic             commit_s;
    logic [IDX_W-1:0] wr_idx_s;
    logic [IDX_W-1:0] rd_idx_s;
    logic             wr_in_range_s;
    logic             rd_in_range_s;

    // Next-state values
    logic                        wr_en_d;
    logic [1:0]                  wr_resp_d;
    logic [S_AXI_DATA_WIDTH-1:0] wr_word_d;
    logic [S_AXI_DATA_WIDTH-1:0] rd_data_d;
    logic [1:0]                  rd_resp_d;

    assign aw_hs_s  = s_axil.AWVALID & ~aw_held_q;
    assign w_hs_s   = s_axil.WVALID  & ~w_held_q;
    assign ar_hs_s  = s_axil.ARVALID & ~rvalid_q;
    // Commit only once both halves are held and the previous response has been taken.
    assign commit_s = aw_held_q & w_held_q & ~bvalid_q;

    assign wr_idx_s      = awaddr_q[ADDR_LSB +: IDX_W];
    assign rd_idx_s      = s_axil.ARADDR[ADDR_LSB +: IDX_W];
    assign wr_in_range_s = (awaddr_q < RANGE_LIMIT);
    assign rd_in_range_s = (s_axil.ARADDR < RANGE_LIMIT);

`ifndef AXIL_REG_SLVERR_EN
    // Range flags only matter when out-of-range rejection is built in.
    logic unused_range_s;
    assign unused_range_s = wr_in_range_s ^ rd_in_range_s;
`endif

    // Ready signals derive only from held/valid flops.
    assign s_axil.AWREADY = ~aw_held_q;
    assign s_axil.WREADY  = ~w_held_q;
    assign s_axil.ARREADY = ~rvalid_q;
    assign s_axil.BVALID  = bvalid_q;
    assign s_axil.BRESP   = bresp_q;
    assign s_axil.RVALID  = rvalid_q;
    assign s_axil.RRESP   = rresp_q;
    assign s_axil.RDATA   = rdata_q;

    // Decide whether the held write may touch storage and which response it gets.
    always_comb begin
        wr_en_d   = 1'b1;
        wr_resp_d = RESP_OKAY;
`ifdef AXIL_REG_SLVERR_EN
        if (!wr_in_range_s) begin
            wr_en_d   = 1'b0;
            wr_resp_d = RESP_SLVERR;
        end else begin
            wr_en_d   = 1'b1;
            wr_resp_d = RESP_OKAY;
        end
`endif
        wr_word_d = merge_bytes(regs_q[wr_idx_s], wdata_q, wstrb_q);
    end

    // Select read data and response for the incoming read address.
    always_comb begin
        rd_data_d = regs_q[rd_idx_s];
        rd_resp_d = RESP_OKAY;
`ifdef AXIL_REG_SLVERR_EN
        if (!rd_in_range_s) begin
            rd_data_d = {S_AXI_DATA_WIDTH{1'b0}};
            rd_resp_d = RESP_SLVERR;
        end else begin
            rd_data_d = regs_q[rd_idx_s];
            rd_resp_d = RESP_OKAY;
        end
`endif
    end

    // Latch AW/W independently, commit them together and hold B until accepted.
    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            aw_held_q <= 1'b0;
            awaddr_q  <= {S_AXI_ADDR_WIDTH{1'b0}};
            w_held_q  <= 1'b0;
            wdata_q   <= {S_AXI_DATA_WIDTH{1'b0}};
            wstrb_q   <= {STRB_W{1'b0}};
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            if (aw_hs_s) begin
                aw_held_q <= 1'b1;
                awaddr_q  <= s_axil.AWADDR;
            end else if (commit_s) begin
                aw_held_q <= 1'b0;
            end
            if (w_hs_s) begin
                w_held_q <= 1'b1;
                wdata_q  <= s_axil.WDATA;
                wstrb_q  <= s_axil.WSTRB;
            end else if (commit_s) begin
                w_held_q <= 1'b0;
            end
            if (commit_s) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_resp_d;
            end else if (bvalid_q && s_axil.BREADY) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // Register array update on commit; a same-edge read still sees the old contents.
    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            for (int i = 0; i < NUM_REG; i++) begin
                regs_q[i] <= {S_AXI_DATA_WIDTH{1'b0}};
            end
        end else if (commit_s && wr_en_d) begin
            regs_q[wr_idx_s] <= wr_word_d;
        end
    end

    // Read path: capture data on AR handshake, hold it until R is accepted.
    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= {S_AXI_DATA_WIDTH{1'b0}};
        end else if (ar_hs_s) begin
            rvalid_q <= 1'b1;
            rresp_q  <= rd_resp_d;
            rdata_q  <= rd_data_d;
        end else if (rvalid_q && s_axil.RREADY) begin
            rvalid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_s_axil_register_file.sv
// Self-checking bench for s_axil_register_file (32-bit data, 16 registers).
// Expected B/R responses are queued when a transaction is issued; a negedge monitor
// records what the DUT hands over, and drain() pairs them up.
module tb_s_axil_register_file;
    localparam int DW = 32;
    localparam int AW = 32;

    logic ACLK = 1'b0;
    logic ARESET;

    always #5 ACLK = ~ACLK;

    s_axil_register_file_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    s_axil_register_file #(
        .S_AXI_DATA_WIDTH(DW),
        .S_AXI_ADDR_WIDTH(AW),
        .NUM_REG(16)
    ) dut (
        .ACLK(ACLK),
        .ARESET(ARESET),
        .s_axil(bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model [16];
    logic [1:0]  exp_b [$];
    logic [1:0]  obs_b [$];
    logic [33:0] exp_r [$];
    logic [33:0] obs_r [$];

    // Record each completed B and R handshake (handshake happens at the following posedge).
    always @(negedge ACLK) begin
        if (ARESET === 1'b1) begin
            if (bus.BVALID && bus.BREADY) obs_b.push_back(bus.BRESP);
            if (bus.RVALID && bus.RREADY) obs_r.push_back({bus.RRESP, bus.RDATA});
        end
    end

    // Hard stop if something hangs despite the bounded waits.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic [3:0] idx;
        logic [1:0] resp;
        idx  = addr[5:2];
        resp = 2'b00;
`ifdef AXIL_REG_SLVERR_EN
        if (addr >= 32'h40) resp = 2'b10;
`endif
        if (resp == 2'b00) begin
            for (int k = 0; k < 4; k++) begin
                if (strb[k]) model[idx][8*k +: 8] = data[8*k +: 8];
            end
        end
        exp_b.push_back(resp);
    endtask

    function automatic logic [33:0] model_read(input logic [31:0] addr);
`ifdef AXIL_REG_SLVERR_EN
        if (addr >= 32'h40) return {2'b10, 32'h0000_0000};
`endif
        return {2'b00, model[addr[5:2]]};
    endfunction

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly);
        bit aw_done;
        bit w_done;
        bit aw_fire;
        bit w_fire;
        int cyc;
        aw_done = 1'b0;
        w_done  = 1'b0;
        cyc     = 0;
        bus.AWADDR = addr;
        bus.WDATA  = data;
        bus.WSTRB  = strb;
        while (!(aw_done && w_done) && cyc < 100) begin
            bus.AWVALID = !aw_done && (cyc >= aw_dly);
            bus.WVALID  = !w_done && (cyc >= w_dly);
            aw_fire = bus.AWVALID && bus.AWREADY;
            w_fire  = bus.WVALID && bus.WREADY;
            tick();
            aw_done = aw_done | aw_fire;
            w_done  = w_done | w_fire;
            cyc++;
        end
        bus.AWVALID = 1'b0;
        bus.WVALID  = 1'b0;
        chk("write_accept", {62'd0, aw_done, w_done}, 64'd3);
        model_write(addr, data, strb);
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [33:0] exp);
        bit fire;
        int cyc;
        fire = 1'b0;
        cyc  = 0;
        bus.ARADDR = addr;
        while (!fire && cyc < 100) begin
            bus.ARVALID = 1'b1;
            fire = bus.ARREADY;
            tick();
            cyc++;
        end
        bus.ARVALID = 1'b0;
        chk("read_accept", {63'd0, fire}, 64'd1);
        exp_r.push_back(exp);
    endtask

    task automatic drain(input string name);
        int cyc;
        cyc = 0;
        while ((obs_b.size() < exp_b.size() || obs_r.size() < exp_r.size()) && cyc < 200) begin
            tick();
            cyc++;
        end
        tick();
        tick();
        chk({name, "_bcount"}, obs_b.size(), exp_b.size());
        chk({name, "_rcount"}, obs_r.size(), exp_r.size());
        while (exp_b.size() > 0 && obs_b.size() > 0) begin
            chk({name, "_bresp"}, obs_b.pop_front(), exp_b.pop_front());
        end
        while (exp_r.size() > 0 && obs_r.size() > 0) begin
            chk({name, "_rdata"}, obs_r.pop_front(), exp_r.pop_front());
        end
        exp_b.delete();
        obs_b.delete();
        exp_r.delete();
        obs_r.delete();
    endtask

    initial begin
        vec_t        seq_tbl [16];
        vec_t        stb_tbl [2];
        logic [33:0] old_val;

        for (int i = 0; i < 16; i++) begin
            seq_tbl[i].addr = 32'(i * 4);
            seq_tbl[i].data = 32'(i + 1);
            seq_tbl[i].strb = 4'hF;
            seq_tbl[i].exp  = 32'(i + 1);
            model[i]        = 32'h0000_0000;
        end
        stb_tbl[0] = '{addr: 32'h08, data: 32'hAABB_CCDD, strb: 4'hF, exp: 32'hAABB_CCDD};
        stb_tbl[1] = '{addr: 32'h08, data: 32'h1122_3344, strb: 4'h5, exp: 32'hAA22_CC44};

        ARESET      = 1'b0;
        bus.AWADDR  = 32'h0;
        bus.AWVALID = 1'b0;
        bus.WDATA   = 32'h0;
        bus.WSTRB   = 4'h0;
        bus.WVALID  = 1'b0;
        bus.BREADY  = 1'b1;
        bus.ARADDR  = 32'h0;
        bus.ARVALID = 1'b0;
        bus.RREADY  = 1'b1;

        // Reset for 5 cycles, then idle-state checks
        repeat (5) @(posedge ACLK);
        #1;
        chk("rst_bvalid_in_reset", bus.BVALID, 1'b0);
        ARESET = 1'b1;
        tick();
        chk("rst_awready", bus.AWREADY, 1'b1);
        chk("rst_wready",  bus.WREADY,  1'b1);
        chk("rst_arready", bus.ARREADY, 1'b1);
        chk("rst_bvalid",  bus.BVALID,  1'b0);
        chk("rst_rvalid",  bus.RVALID,  1'b0);
        chk("rst_bresp",   bus.BRESP,   2'b00);
        chk("rst_rresp",   bus.RRESP,   2'b00);
        chk("rst_rdata",   bus.RDATA,   32'h0);
        for (int i = 0; i < 16; i++) axi_read(32'(i * 4), {2'b00, 32'h0000_0000});
        drain("reset_reads");

        // Sequential writes (W one cycle after AW), then read back
        for (int i = 0; i < 16; i++) axi_write(seq_tbl[i].addr, seq_tbl[i].data, seq_tbl[i].strb, 0, 1);
        drain("seq_writes");
        for (int i = 0; i < 16; i++) axi_read(seq_tbl[i].addr, {2'b00, seq_tbl[i].exp});
        drain("seq_reads");

        // Byte strobes
        for (int i = 0; i < 2; i++) axi_write(stb_tbl[i].addr, stb_tbl[i].data, stb_tbl[i].strb, 0, 0);
        drain("strobe_writes");
        axi_read(stb_tbl[1].addr, {2'b00, stb_tbl[1].exp});
        drain("strobe_read");

        // W three cycles ahead of AW
        bus.WDATA  = 32'h0000_BEEF;
        bus.WSTRB  = 4'hF;
        bus.WVALID = 1'b1;
        chk("ord_wready_before", bus.WREADY, 1'b1);
        tick();
        bus.WVALID = 1'b0;
        chk("ord_wready_after_w", bus.WREADY, 1'b0);
        chk("ord_no_b_before_aw", bus.BVALID, 1'b0);
        tick();
        tick();
        chk("ord_wready_still_0", bus.WREADY, 1'b0);
        bus.AWADDR  = 32'h10;
        bus.AWVALID = 1'b1;
        chk("ord_awready", bus.AWREADY, 1'b1);
        tick();
        bus.AWVALID = 1'b0;
        chk("ord_bvalid_at_hs", bus.BVALID, 1'b0);
        tick();
        chk("ord_bvalid_next", bus.BVALID, 1'b1);
        model_write(32'h10, 32'h0000_BEEF, 4'hF);
        drain("ord_w_first");
        // AW and W in the same cycle
        axi_write(32'h14, 32'h0000_CAFE, 4'hF, 0, 0);
        chk("same_bvalid_at_hs", bus.BVALID, 1'b0);
        tick();
        chk("same_bvalid_next", bus.BVALID, 1'b1);
        drain("ord_same");
        axi_read(32'h10, model_read(32'h10));
        axi_read(32'h14, model_read(32'h14));
        drain("ord_reads");

        // Backpressure on both response channels
        bus.BREADY = 1'b0;
        axi_write(32'h18, 32'h0000_0055, 4'hF, 0, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_bvalid_held", bus.BVALID, 1'b1);
            chk("bp_bresp_held",  bus.BRESP,  2'b00);
            tick();
        end
        axi_write(32'h1C, 32'h0000_0066, 4'hF, 0, 0);
        chk("bp_awready_0", bus.AWREADY, 1'b0);
        chk("bp_wready_0",  bus.WREADY,  1'b0);
        bus.RREADY = 1'b0;
        axi_read(32'h18, model_read(32'h18));
        for (int i = 0; i < 5; i++) begin
            chk("bp_rvalid_held", bus.RVALID,  1'b1);
            chk("bp_rdata_held",  bus.RDATA,   32'h0000_0055);
            chk("bp_arready_0",   bus.ARREADY, 1'b0);
            tick();
        end
        bus.BREADY = 1'b1;
        bus.RREADY = 1'b1;
        drain("backpressure");
        axi_read(32'h1C, model_read(32'h1C));
        drain("bp_queued_write");

        // Out-of-range access (SLVERR or alias, depending on build)
        axi_write(32'h40, 32'h0000_005A, 4'hF, 0, 0);
        drain("range_write");
        axi_read(32'h40, model_read(32'h40));
        axi_read(32'h00, model_read(32'h00));
        drain("range_reads");

        // Write commit and read on the same edge return the pre-write value
        old_val = model_read(32'h0C);
        axi_write(32'h0C, 32'h0000_0007, 4'hF, 0, 0);
        axi_read(32'h0C, old_val);
        chk("hazard_bvalid", bus.BVALID, 1'b1);
        chk("hazard_rvalid", bus.RVALID, 1'b1);
        drain("hazard");
        axi_read(32'h0C, {2'b00, 32'h0000_0007});
        drain("hazard_after");

        // Reset while a write response is pending drops it
        bus.BREADY = 1'b0;
        axi_write(32'h20, 32'h0000_0099, 4'hF, 0, 0);
        tick();
        chk("midrst_bvalid_before", bus.BVALID, 1'b1);
        ARESET = 1'b0;
        #1;
        chk("midrst_bvalid",  bus.BVALID,  1'b0);
        chk("midrst_awready", bus.AWREADY, 1'b1);
        exp_b.delete();
        obs_b.delete();
        for (int i = 0; i < 16; i++) model[i] = 32'h0000_0000;
        tick();
        ARESET     = 1'b1;
        bus.BREADY = 1'b1;
        tick();
        axi_read(32'h20, {2'b00, 32'h0000_0000});
        axi_read(32'h00, {2'b00, 32'h0000_0000});
        drain("midrst_reads");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
